approx_mult_pipe: RTL and testbench



---
 rtl/approx_mult_pkg.sv | 27 ++
 rtl/approx_mult_pipe_core.sv | 51 +++++
 rtl/approx_mult_pipe.sv | 155 +++++++++++++++
 tb/tb_approx_mult_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
//   Shared definitions for the approximate multiplier pipeline:
//   - mode encodings carried alongside each operand beat
//   - comp_const(): compensation constant added in approximate mode
//   - params_ok(): elaboration-time legality check of the block parameters
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 16;

  // Compensation for the dropped low columns: half the weight of the
  // lowest kept column, i.e. 2^(k-1); nothing to compensate when k = 0.
  function automatic logic [31:0] comp_const(input int k);
    return (k >= 1) ? (32'd1 << (k - 1)) : 32'd0;
  endfunction

  function automatic bit params_ok(input int width, input int trunc_k,
                                   input int pipe_mid, input int cnt_w);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (trunc_k >= 0) && (trunc_k <= width) &&
           ((pipe_mid == 0) || (pipe_mid == 1)) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/approx_mult_pipe_core.sv
// approx_mult_core
//   Purely combinational multiplier datapath, split into two halves so the
//   wrapper can optionally register between them:
//   - reduction half : a_i, b_i, mode_i -> sum_o (sum of partial-product
//                      rows, low TRUNC_K columns masked in approximate mode)
//                      and add_c_o (compensation constant must be added)
//   - final-add half : sum_i, add_c_i -> p_o (sum plus optional constant)
module approx_mult_core
  import approx_mult_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TRUNC_K = 4
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               mode_i,
  output logic [2*WIDTH-1:0] sum_o,
  output logic               add_c_o,
  input  logic [2*WIDTH-1:0] sum_i,
  input  logic               add_c_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int PW = 2 * WIDTH;

  // Row i of the partial-product array is b << i, so its bit positions are
  // already the product columns i+j; masking a row by column drops exactly
  // the terms with i+j < TRUNC_K.
  localparam logic [PW-1:0] COL_MASK = ~((PW'(1) << TRUNC_K) - PW'(1));
  localparam logic [PW-1:0] C_VAL    = PW'(comp_const(TRUNC_K));

  logic [PW-1:0] row;

  always_comb begin
    sum_o = '0;
    row   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = a_i[i] ? (PW'(b_i) << i) : '0;
      if (mode_i == MODE_APPROX) begin
        row = row & COL_MASK;
      end
      sum_o = sum_o + row;
    end
  end

  // A zero operand must give a zero product, so the constant is suppressed.
  assign add_c_o = (mode_i == MODE_APPROX) && (a_i != '0) && (b_i != '0);

  assign p_o = sum_i + (add_c_i ? C_VAL : '0);

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Pipelined exact/approximate unsigned multiplier with valid/ready
//   handshakes and a completed-transaction counter.
//   Ports:
//     clk, rst_n                    clock, async active-low reset
//     in_valid/in_ready             operand beat handshake
//     in_a, in_b, in_mode           operands and mode (0 exact, 1 approx)
//     out_valid/out_ready           result beat handshake
//     out_p, out_mode               product and the mode it was built with
//     txn_count                     results taken at the output (wraps)
//   Stages: operand register -> [optional mid register] -> output register.
//
//   Handshake: a beat moves across an interface on a cycle where valid and
//   ready are both high. The whole pipe advances together when
//   adv = !out_valid | out_ready; in_ready equals adv and never depends on
//   in_valid. When adv is low every stage (data and valid bit) holds, so the
//   output is stable under backpressure; bubbles travel like beats.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TRUNC_K  = 4,
  parameter int PIPE_MID = 0,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_mode,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int PW = 2 * WIDTH;

  if (!params_ok(WIDTH, TRUNC_K, PIPE_MID, CNT_W)) begin : g_bad_params
    $error("approx_mult_pipe: illegal WIDTH/TRUNC_K/PIPE_MID/CNT_W");
  end

  logic adv;

  // Operand stage
  logic             s0_valid_q;
  logic [WIDTH-1:0] s0_a_q;
  logic [WIDTH-1:0] s0_b_q;
  logic             s0_mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s0_mode_q  <= MODE_EXACT;
    end else if (adv) begin
      s0_valid_q <= in_valid;
      s0_a_q     <= in_a;
      s0_b_q     <= in_b;
      s0_mode_q  <= in_mode;
    end
  end

  logic [PW-1:0] red_sum;
  logic          red_add_c;
  logic [PW-1:0] mid_sum;
  logic          mid_add_c;
  logic          mid_valid;
  logic          mid_mode;
  logic [PW-1:0] out_p_d;

  approx_mult_core #(
    .WIDTH  (WIDTH),
    .TRUNC_K(TRUNC_K)
  ) u_core (
    .a_i    (s0_a_q),
    .b_i    (s0_b_q),
    .mode_i (s0_mode_q),
    .sum_o  (red_sum),
    .add_c_o(red_add_c),
    .sum_i  (mid_sum),
    .add_c_i(mid_add_c),
    .p_o    (out_p_d)
  );

  // Optional register between reduction and final add
  if (PIPE_MID != 0) begin : g_mid
    logic          mid_valid_q;
    logic          mid_mode_q;
    logic          mid_add_c_q;
    logic [PW-1:0] mid_sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mid_valid_q <= 1'b0;
        mid_mode_q  <= MODE_EXACT;
        mid_add_c_q <= 1'b0;
        mid_sum_q   <= '0;
      end else if (adv) begin
        mid_valid_q <= s0_valid_q;
        mid_mode_q  <= s0_mode_q;
        mid_add_c_q <= red_add_c;
        mid_sum_q   <= red_sum;
      end
    end

    assign mid_valid = mid_valid_q;
    assign mid_mode  = mid_mode_q;
    assign mid_add_c = mid_add_c_q;
    assign mid_sum   = mid_sum_q;
  end else begin : g_no_mid
    assign mid_valid = s0_valid_q;
    assign mid_mode  = s0_mode_q;
    assign mid_add_c = red_add_c;
    assign mid_sum   = red_sum;
  end

  // Output stage and counter
  logic             out_valid_q;
  logic             out_mode_q;
  logic [PW-1:0]    out_p_q;
  logic [CNT_W-1:0] txn_count_q;
  logic [CNT_W-1:0] txn_count_d;

  assign txn_count_d = (out_valid_q && out_ready) ? txn_count_q + CNT_W'(1)
                                                  : txn_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_mode_q  <= MODE_EXACT;
      out_p_q     <= '0;
      txn_count_q <= '0;
    end else begin
      txn_count_q <= txn_count_d;
      if (adv) begin
        out_valid_q <= mid_valid;
        out_mode_q  <= mid_mode;
        out_p_q     <= out_p_d;
      end
    end
  end

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_mode  = out_mode_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
module tb_approx_mult_pipe;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8x8, TRUNC_K=4, no mid register
  logic [7:0]  a8, b8;
  logic        m8, iv8, ir8, ov8, or8, om8;
  logic [15:0] op8;
  logic [31:0] tc8;

  // 16x16, TRUNC_K=0, mid register
  logic [15:0] a16, b16;
  logic        m16, iv16, ir16, ov16, or16, om16;
  logic [31:0] op16;
  logic [31:0] tc16;

  approx_mult_pipe #(.WIDTH(8), .TRUNC_K(4), .PIPE_MID(0), .CNT_W(32)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_mode(m8), .out_valid(ov8), .out_ready(or8), .out_p(op8), .out_mode(om8),
    .txn_count(tc8)
  );

  approx_mult_pipe #(.WIDTH(16), .TRUNC_K(0), .PIPE_MID(1), .CNT_W(32)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_mode(m16), .out_valid(ov16), .out_ready(or16), .out_p(op16), .out_mode(om16),
    .txn_count(tc16)
  );

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q8[$];
  logic [32:0] exp_q16[$];
  int          acyc8[$], astl8[$], acyc16[$], astl16[$];
  logic [15:0] got8[$];
  logic        gotm8[$];
  logic [31:0] got16[$];
  int cyc = 0, stall8 = 0, stall16 = 0, cnt8 = 0, cnt16 = 0, acc8 = 0;
  int checks = 0, errors = 0;

  // Reference: direct sum over individual bit products a_i*b_j*2^(i+j).
  function automatic logic [63:0] ref_mult(input logic [63:0] a, input logic [63:0] b,
                                           input logic approx, input int w, input int k);
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (a[i] && b[j] && (!approx || (i + j >= k))) s = s + (64'd1 << (i + j));
    if (approx && (k >= 1) && (a != 64'd0) && (b != 64'd0)) s = s + (64'd1 << (k - 1));
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: scoreboard at the falling edge, return #1 after rising edge.
  task automatic step();
    logic [16:0] e8;
    logic [32:0] e16;
    @(negedge clk);
    if (rst_n) begin
      if (ov8 && or8) begin
        if (exp_q8.size() == 0) chk("sb8_unexpected_valid", 64'(ov8), 64'd0);
        else begin
          e8 = exp_q8.pop_front();
          chk("sb8_p", 64'(op8), 64'(e8[15:0]));
          chk("sb8_mode", 64'(om8), 64'(e8[16]));
          chk("sb8_latency", 64'(cyc - acyc8.pop_front()), 64'(2 + stall8 - astl8.pop_front()));
          chk("sb8_txn", 64'(tc8), 64'(cnt8));
          cnt8++;
          got8.push_back(op8);
          gotm8.push_back(om8);
        end
      end
      if (iv8 && ir8) begin
        exp_q8.push_back({m8, 16'(ref_mult(64'(a8), 64'(b8), m8, 8, 4))});
        acyc8.push_back(cyc);
        astl8.push_back(stall8);
        acc8++;
      end
      if (ov8 && !or8) stall8++;

      if (ov16 && or16) begin
        if (exp_q16.size() == 0) chk("sb16_unexpected_valid", 64'(ov16), 64'd0);
        else begin
          e16 = exp_q16.pop_front();
          chk("sb16_p", 64'(op16), 64'(e16[31:0]));
          chk("sb16_mode", 64'(om16), 64'(e16[32]));
          chk("sb16_latency", 64'(cyc - acyc16.pop_front()), 64'(3 + stall16 - astl16.pop_front()));
          chk("sb16_txn", 64'(tc16), 64'(cnt16));
          cnt16++;
          got16.push_back(op16);
        end
      end
      if (iv16 && ir16) begin
        exp_q16.push_back({m16, 32'(ref_mult(64'(a16), 64'(b16), m16, 16, 0))});
        acyc16.push_back(cyc);
        astl16.push_back(stall16);
      end
      if (ov16 && !or16) stall16++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b1; or16 = 1'b1;
    for (int k = 0; k < 50 && (exp_q8.size() != 0 || exp_q16.size() != 0); k++) step();
    chk("drain8_empty", 64'(exp_q8.size()), 64'd0);
    chk("drain16_empty", 64'(exp_q16.size()), 64'd0);
  endtask

  function automatic logic [7:0] pick8();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 8'd0;
    if (r == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  // Safety net: the run must always end.
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] t2_exp[3];
    a8 = '0; b8 = '0; m8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    a16 = '0; b16 = '0; m16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_out_p", 64'(op8), 64'd0);
    chk("rst_out_mode", 64'(om8), 64'd0);
    chk("rst_txn", 64'(tc8), 64'd0);
    chk("rst_in_ready", 64'(ir8), 64'd1);
    chk("rst_out_valid16", 64'(ov16), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: 255*255 exact then approximate, back to back
    a8 = 8'd255; b8 = 8'd255; m8 = 1'b0; iv8 = 1'b1;
    step();
    m8 = 1'b1;
    step();
    iv8 = 1'b0;
    chk("t1_valid0", 64'(ov8), 64'd1);
    chk("t1_p0", 64'(op8), 64'd65025);
    chk("t1_mode0", 64'(om8), 64'd0);
    step();
    chk("t1_valid1", 64'(ov8), 64'd1);
    chk("t1_p1", 64'(op8), 64'd64984);
    chk("t1_mode1", 64'(om8), 64'd1);
    step();
    chk("t1_idle", 64'(ov8), 64'd0);
    chk("t1_txn", 64'(tc8), 64'd2);

    // 2: approximate-mode corners
    got8.delete(); gotm8.delete();
    t2_exp = '{16'd0, 16'd8, 16'd264};
    m8 = 1'b1; iv8 = 1'b1;
    a8 = 8'd0;  b8 = 8'd200; step();
    a8 = 8'd1;  b8 = 8'd1;   step();
    a8 = 8'd16; b8 = 8'd16;  step();
    drain();
    chk("t2_count", 64'(got8.size()), 64'd3);
    for (int i = 0; i < 3 && i < got8.size(); i++) chk("t2_p", 64'(got8[i]), 64'(t2_exp[i]));

    // 3: backpressure mid-stream
    got8.delete(); gotm8.delete();
    or8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a8 = 8'(i); b8 = 8'd3; m8 = 1'b0; iv8 = 1'b1;
      if (i == 2) begin
        or8 = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          chk("t3_in_ready_hold", 64'(ir8), 64'd0);
          chk("t3_valid_hold", 64'(ov8), 64'd1);
          chk("t3_p_hold", 64'(op8), 64'd0);
          step();
        end
        or8 = 1'b1;
      end
      step();
    end
    drain();
    chk("t3_count", 64'(got8.size()), 64'd5);
    for (int i = 0; i < 5 && i < got8.size(); i++) chk("t3_p", 64'(got8[i]), 64'(3 * i));
    chk("t3_txn", 64'(tc8), 64'd10);

    // 4: asynchronous reset with beats in flight
    got8.delete(); gotm8.delete();
    m8 = 1'b0; iv8 = 1'b1;
    a8 = 8'd5; b8 = 8'd7; step();
    a8 = 8'd9; step();
    iv8 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t4_valid_async", 64'(ov8), 64'd0);
    chk("t4_txn_async", 64'(tc8), 64'd0);
    chk("t4_p_async", 64'(op8), 64'd0);
    exp_q8.delete(); acyc8.delete(); astl8.delete();
    exp_q16.delete(); acyc16.delete(); astl16.delete();
    cnt8 = 0; cnt16 = 0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_no_stale", 64'(ov8), 64'd0);
    end
    chk("t4_got", 64'(got8.size()), 64'd0);

    // 5: 16-bit, TRUNC_K=0, mid register: approx equals exact, 3-cycle latency
    got16.delete();
    a16 = 16'hFFFF; b16 = 16'hFFFF; m16 = 1'b1; iv16 = 1'b1;
    step();
    m16 = 1'b0;
    step();
    iv16 = 1'b0;
    step();
    chk("t5_valid0", 64'(ov16), 64'd1);
    chk("t5_p0", 64'(op16), 64'd4294836225);
    chk("t5_mode0", 64'(om16), 64'd1);
    step();
    chk("t5_p1", 64'(op16), 64'd4294836225);
    chk("t5_mode1", 64'(om16), 64'd0);
    drain();
    chk("t5_txn", 64'(tc16), 64'd2);

    // 6: random stress on both instances
    begin
      int start;
      start = acc8;
      for (int c = 0; c < 40000 && (acc8 - start) < 10000; c++) begin
        iv8  = ($urandom_range(0, 9) < 7);
        or8  = ($urandom_range(0, 3) != 0);
        a8   = pick8();
        b8   = pick8();
        m8   = 1'($urandom_range(0, 1));
        iv16 = 1'($urandom_range(0, 1));
        or16 = ($urandom_range(0, 3) != 0);
        a16  = 16'($urandom);
        b16  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
        m16  = 1'($urandom_range(0, 1));
        step();
      end
      chk("t6_beats", 64'(acc8 - start), 64'd10000);
    end
    drain();
    chk("t6_txn8", 64'(tc8), 64'(cnt8));
    chk("t6_txn16", 64'(tc16), 64'(cnt16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
